// File: rtl/eth_rx_fcs_check.sv
// Receive-side Ethernet FCS checker: strips the 4 trailing FCS bytes through a
// 4-byte delay line and reports CRC, length and GMII-error status per frame.
module eth_rx_fcs_check #(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic        in_err,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  output logic        frame_done,
  output logic        crc_err,
  output logic        len_err,
  output logic        rx_err,
  output logic [15:0] frame_len
);

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [15:0] MIN_LEN     = 16'(MIN_FRAME_LEN);
  localparam logic [15:0] MAX_LEN     = 16'(MAX_FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rx_acc_q, rx_acc_d;
  logic [31:0] dl_q, dl_d;

  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic        frame_done_q, frame_done_d;
  logic        crc_err_q, crc_err_d;
  logic        len_err_q, len_err_d;
  logic        rx_err_q, rx_err_d;
  logic [15:0] frame_len_q, frame_len_d;

  logic [31:0] crc_base;
  logic [15:0] cnt_base;
  logic        rx_base;

  // Reflected CRC-32, one byte per call, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    crc_d        = crc_q;
    cnt_d        = cnt_q;
    rx_acc_d     = rx_acc_q;
    dl_d         = dl_q;
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    out_last_d   = 1'b0;
    frame_done_d = 1'b0;
    crc_err_d    = crc_err_q;
    len_err_d    = len_err_q;
    rx_err_d     = rx_err_q;
    frame_len_d  = frame_len_q;

    // A byte arriving in IDLE opens a frame, so accumulators start fresh.
    crc_base = (state_q == IDLE) ? CRC_INIT : crc_q;
    cnt_base = (state_q == IDLE) ? 16'h0000 : cnt_q;
    rx_base  = (state_q == IDLE) ? 1'b0 : rx_acc_q;

    if (in_valid) begin
      crc_d    = crc32_byte(crc_base, in_data);
      cnt_d    = (cnt_base == 16'hFFFF) ? cnt_base : cnt_base + 16'd1;
      rx_acc_d = rx_base | in_err;
      dl_d     = {dl_q[23:0], in_data};

      if (state_q == IDLE) begin
        crc_err_d   = 1'b0;
        len_err_d   = 1'b0;
        rx_err_d    = 1'b0;
        frame_len_d = 16'h0000;
      end

      case (state_q)
        IDLE:    state_d = FILL;
        FILL:    if (cnt_d == 16'd4) state_d = STREAM;
        STREAM: begin
          out_valid_d = 1'b1;
          out_data_d  = dl_q[31:24];
          out_last_d  = in_last;
        end
        default: state_d = IDLE;
      endcase

      if (in_last) begin
        state_d      = IDLE;
        frame_done_d = 1'b1;
        crc_err_d    = (crc_d != CRC_RESIDUE);
        len_err_d    = (cnt_d < MIN_LEN) || (cnt_d > MAX_LEN);
        rx_err_d     = rx_acc_d;
        frame_len_d  = cnt_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      crc_q        <= CRC_INIT;
      cnt_q        <= 16'h0000;
      rx_acc_q     <= 1'b0;
      dl_q         <= 32'h0;
      out_data_q   <= 8'h00;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      crc_err_q    <= 1'b0;
      len_err_q    <= 1'b0;
      rx_err_q     <= 1'b0;
      frame_len_q  <= 16'h0000;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      cnt_q        <= cnt_d;
      rx_acc_q     <= rx_acc_d;
      dl_q         <= dl_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      crc_err_q    <= crc_err_d;
      len_err_q    <= len_err_d;
      rx_err_q     <= rx_err_d;
      frame_len_q  <= frame_len_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;
  assign crc_err    = crc_err_q;
  assign len_err    = len_err_q;
  assign rx_err     = rx_err_q;
  assign frame_len  = frame_len_q;

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Directed bench for eth_rx_fcs_check: drives whole frames, collects the
// stripped byte stream and per-frame status, and compares against constants.
module tb_eth_rx_fcs_check;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_err;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        frame_done;
  logic        crc_err;
  logic        len_err;
  logic        rx_err;
  logic [15:0] frame_len;

  eth_rx_fcs_check #(
    .MIN_FRAME_LEN(64),
    .MAX_FRAME_LEN(1518)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_err    (in_err),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .frame_done(frame_done),
    .crc_err   (crc_err),
    .len_err   (len_err),
    .rx_err    (rx_err),
    .frame_len (frame_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ce;
    logic        le;
    logic        re;
    logic [15:0] fl;
    logic        ol;
    int          nb;
    logic [7:0]  lb;
  } done_t;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  fr[$];
  logic [7:0]  out_q[$];
  done_t       done_q[$];
  logic [18:0] post_q[$];
  int          nbytes = 0;
  int          ol_cnt = 0;
  bit          post_pend = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (post_pend) begin
      post_q.push_back({len_err, crc_err, rx_err, frame_len});
      post_pend = 0;
    end
    if (out_valid) begin
      out_q.push_back(out_data);
      nbytes++;
    end
    if (out_last) ol_cnt++;
    if (frame_done) begin
      done_q.push_back('{ce: crc_err, le: len_err, re: rx_err, fl: frame_len,
                         ol: out_last, nb: nbytes, lb: out_data});
      nbytes    = 0;
      post_pend = 1;
    end
  end

  task automatic clear_mon();
    out_q.delete();
    done_q.delete();
    post_q.delete();
    nbytes = 0;
    ol_cnt = 0;
  endtask

  // Payload plus a correct FCS, appended low byte first.
  task automatic build_frame(input int n_total, input int seed);
    logic [31:0] c;
    logic [7:0]  b;
    fr.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n_total - 4; i++) begin
      b = 8'(seed + i * 13 + (i >> 3));
      fr.push_back(b);
      c = crc_byte(c, b);
    end
    c = ~c;
    fr.push_back(c[7:0]);
    fr.push_back(c[15:8]);
    fr.push_back(c[23:16]);
    fr.push_back(c[31:24]);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input logic err);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_err   = err;
  endtask

  task automatic go_idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_err   = 1'b0;
  endtask

  // stop_after > 0 sends only that many bytes and leaves the frame open.
  task automatic send_frame(input bit gaps, input int flip_idx, input int err_idx,
                            input bit keep, input int stop_after);
    int n;
    n = (stop_after > 0) ? stop_after : fr.size();
    $display("tx frame: %0d of %0d bytes, gaps=%0d flip=%0d err=%0d",
             n, fr.size(), gaps, flip_idx, err_idx);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 3 == 2)) go_idle();
      send_byte(fr[i] ^ ((i == flip_idx) ? 8'h01 : 8'h00),
                (stop_after == 0) && (i == fr.size() - 1), i == err_idx);
    end
    if (!keep) go_idle();
  endtask

  task automatic wait_done(input string tag, input int n);
    for (int k = 0; k < 200 && done_q.size() < n; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check_val({tag, "_done_cnt"}, done_q.size(), n);
  endtask

  function automatic done_t rec_at(input int k);
    done_t r;
    r = '{ce: 1'bx, le: 1'bx, re: 1'bx, fl: 16'hxxxx, ol: 1'bx, nb: -1, lb: 8'hxx};
    if (k < done_q.size()) r = done_q[k];
    return r;
  endfunction

  task automatic check_rec(input string tag, input int k, input logic ce, input logic le,
                           input logic re, input logic [15:0] fl, input int nb);
    done_t r;
    r = rec_at(k);
    $display("rx frame %s: len=%0d out_bytes=%0d crc_err=%0b len_err=%0b rx_err=%0b",
             tag, r.fl, r.nb, r.ce, r.le, r.re);
    check_val({tag, "_crc_err"}, 32'(r.ce), 32'(ce));
    check_val({tag, "_len_err"}, 32'(r.le), 32'(le));
    check_val({tag, "_rx_err"}, 32'(r.re), 32'(re));
    check_val({tag, "_frame_len"}, 32'(r.fl), 32'(fl));
    check_val({tag, "_nbytes"}, 32'(r.nb), 32'(nb));
    check_val({tag, "_out_last_at_done"}, 32'(r.ol), (nb > 0) ? 32'd1 : 32'd0);
  endtask

  task automatic check_payload(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= out_q.size() || out_q[i] !== fr[i]) bad++;
    end
    check_val({tag, "_payload_bad"}, bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    done_t       r;
    logic [18:0] p;
    rst      = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_err   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outputs",
              {out_data, out_valid, out_last, frame_done, crc_err, len_err, rx_err, frame_len},
              32'h0);
    @(negedge clk);
    rst = 1'b1;

    // "123456789" with its FCS: short frame, good CRC.
    clear_mon();
    fr.delete();
    for (int i = 0; i < 9; i++) fr.push_back(8'h31 + 8'(i));
    fr.push_back(8'h26);
    fr.push_back(8'h39);
    fr.push_back(8'hF4);
    fr.push_back(8'hCB);
    send_frame(0, -1, -1, 0, 0);
    wait_done("t1", 1);
    check_rec("t1", 0, 1'b0, 1'b1, 1'b0, 16'd13, 9);
    for (int i = 0; i < 9; i++)
      check_val($sformatf("t1_byte%0d", i), (i < out_q.size()) ? out_q[i] : 8'h00, 8'h31 + 8'(i));
    check_val("t1_last_byte", rec_at(0).lb, 8'h39);
    p = (post_q.size() > 0) ? post_q[0] : 19'h7FFFF;
    check_val("t1_len_err_held", p[18], 1'b1);

    // 64-byte good frame with gaps.
    clear_mon();
    build_frame(64, 5);
    send_frame(1, -1, -1, 0, 0);
    wait_done("t2", 1);
    check_rec("t2", 0, 1'b0, 1'b0, 1'b0, 16'd64, 60);
    check_payload("t2", 60);
    check_val("t2_last_byte", rec_at(0).lb, fr[59]);

    // Same frame, bit 0 of byte 10 flipped.
    clear_mon();
    send_frame(1, 9, -1, 0, 0);
    wait_done("t3", 1);
    check_rec("t3", 0, 1'b1, 1'b0, 1'b0, 16'd64, 60);

    // GMII error mid-frame: flagged, frame still delivered.
    clear_mon();
    send_frame(0, -1, 29, 0, 0);
    wait_done("t4", 1);
    check_rec("t4", 0, 1'b0, 1'b0, 1'b1, 16'd64, 60);
    check_payload("t4", 60);

    // 3-byte runt: nothing forwarded.
    clear_mon();
    fr.delete();
    fr.push_back(8'h01);
    fr.push_back(8'h02);
    fr.push_back(8'h03);
    send_frame(0, -1, -1, 0, 0);
    wait_done("t5", 1);
    check_rec("t5", 0, 1'b1, 1'b1, 1'b0, 16'd3, 0);
    check_val("t5_out_count", out_q.size(), 0);
    check_val("t5_out_last_count", ol_cnt, 0);

    // 4-byte frame ends while still filling the delay line.
    clear_mon();
    build_frame(4, 0);
    send_frame(0, -1, -1, 0, 0);
    wait_done("t6", 1);
    check_rec("t6", 0, 1'b0, 1'b1, 1'b0, 16'd4, 0);
    check_val("t6_out_count", out_q.size(), 0);

    // Largest legal frame.
    clear_mon();
    build_frame(1518, 77);
    send_frame(0, -1, -1, 0, 0);
    wait_done("t7", 1);
    check_rec("t7", 0, 1'b0, 1'b0, 1'b0, 16'd1518, 1514);

    // Oversize frame immediately followed by a good 64-byte frame.
    clear_mon();
    build_frame(1519, 9);
    send_frame(0, -1, -1, 1, 0);
    build_frame(64, 33);
    send_frame(0, -1, -1, 0, 0);
    wait_done("t8", 2);
    check_rec("t8a", 0, 1'b0, 1'b1, 1'b0, 16'd1519, 1515);
    check_rec("t8b", 1, 1'b0, 1'b0, 1'b0, 16'd64, 60);
    p = (post_q.size() > 0) ? post_q[0] : 19'h7FFFF;
    check_val("t8_status_cleared", p, 19'h0);

    // Reset after byte 20 of a frame.
    clear_mon();
    build_frame(64, 101);
    send_frame(0, -1, -1, 1, 20);
    @(posedge clk);
    #1;
    check_val("t9_out_valid_before_rst", out_valid, 1'b1);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check_val("t9_outputs_in_rst",
              {out_data, out_valid, out_last, frame_done, crc_err, len_err, rx_err, frame_len},
              32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_val("t9_no_done_after_rst", done_q.size(), 0);
    check_val("t9_no_out_last_after_rst", ol_cnt, 0);
    clear_mon();
    build_frame(64, 55);
    send_frame(0, -1, -1, 0, 0);
    wait_done("t9", 1);
    check_rec("t9", 0, 1'b0, 1'b0, 1'b0, 16'd64, 60);
    check_payload("t9", 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
